// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage responder for the multi-cycle CPU.
// Performs one load or store per MEM_en pulse over a req/ack data-memory bus.
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   MEM_en, L_or_S            start pulse (sampled in IDLE), 0 = load / 1 = store
//   size, unsigned_ld         00 byte, 01 half, 10 word, 11 illegal; zero-extend loads
//   addr, wdata               byte address, store data
//   mem_done, mem_err         one-cycle completion pulse, error flag coincident with it
//   rdata                     extended load result, held until the next completed load
//   bus_req/we/addr/be/wdata  data-memory request channel, stable while in REQ
//   bus_ack, bus_rdata        bus handshake and read data
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_en,
    input  logic        L_or_S,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        mem_done,
    output logic        mem_err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;

    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

    logic [1:0]  state, state_nxt;
    logic [3:0]  tmo_cnt;
    logic [1:0]  lat_off;
    logic [1:0]  lat_size;
    logic        lat_uns;
    logic        req_legal;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    // Request check and bus-field encoding from the live inputs (used only in IDLE).
    always_comb begin
        req_legal  = 1'b1;
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        unique case (size)
            2'b00: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wdata[7:0]}};
            end
            2'b01: begin
                req_legal  = ~addr[0];
                be_calc    = 4'b0011 << {addr[1], 1'b0};
                wdata_calc = {2{wdata[15:0]}};
            end
            2'b10: req_legal = (addr[1:0] == 2'b00);
            default: req_legal = 1'b0;
        endcase
    end

    // Lane extraction and extension of the returned word, using the latched request.
    always_comb begin
        unique case (lat_off)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = lat_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        unique case (lat_size)
            2'b00:   ld_ext = {{24{ld_byte[7] & ~lat_uns}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_half[15] & ~lat_uns}}, ld_half};
            default: ld_ext = bus_rdata;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (MEM_en) state_nxt = req_legal ? REQ : ERR;
            REQ: begin
                if (bus_ack)                     state_nxt = DONE;
                else if (tmo_cnt == TIMEOUT_LAST) state_nxt = ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tmo_cnt   <= 4'd0;
            lat_off   <= 2'd0;
            lat_size  <= 2'd0;
            lat_uns   <= 1'b0;
            rdata     <= 32'd0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_be    <= 4'd0;
            bus_wdata <= 32'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && MEM_en && req_legal) begin
                tmo_cnt   <= 4'd0;
                lat_off   <= addr[1:0];
                lat_size  <= size;
                lat_uns   <= unsigned_ld;
                bus_we    <= L_or_S;
                bus_addr  <= {addr[31:2], 2'b00};
                bus_be    <= be_calc;
                bus_wdata <= wdata_calc;
            end
            if (state == REQ) begin
                if (bus_ack) begin
                    // Captured on the ack cycle so rdata is already valid with mem_done.
                    if (!bus_we) rdata <= ld_ext;
                end else begin
                    tmo_cnt <= tmo_cnt + 4'd1;
                end
            end
        end
    end

    // Decoded from the state register so an asynchronous reset drops bus_req at once.
    assign bus_req  = (state == REQ);
    assign mem_done = (state == DONE) || (state == ERR);
    assign mem_err  = (state == ERR);

endmodule
